// File: rtl/bp_me_pkg.sv
// bp_me_pkg: shared types for the CCE microcode fetch controller
// Macro BP_CCE_FETCH_BRANCH_BYPASS_EN removes the redirect state (zero-bubble branches).
package bp_me_pkg;
`ifdef BP_CCE_FETCH_BRANCH_BYPASS_EN
    typedef enum logic [1:0] {
        e_halt  = 2'd0,
        e_prime = 2'd1,
        e_run   = 2'd2
    } bp_cce_fetch_state_e;
`else
    typedef enum logic [1:0] {
        e_halt     = 2'd0,
        e_prime    = 2'd1,
        e_run      = 2'd2,
        e_redirect = 2'd3
    } bp_cce_fetch_state_e;
`endif
endpackage

// File: rtl/bp_cce_fetch_pc_gen.sv
// bp_cce_fetch_pc_gen: next microcode PC selection (hold / sequential with wrap / branch)
// Ports: pc_i current PC, yumi_i instruction consumed, branch_v_i/branch_target_i redirect,
//        next_pc_o PC to read next.
module bp_cce_fetch_pc_gen #(
    parameter int cce_pc_width_p = 8
) (
    input  logic [cce_pc_width_p-1:0] pc_i,
    input  logic                      yumi_i,
    input  logic                      branch_v_i,
    input  logic [cce_pc_width_p-1:0] branch_target_i,
    output logic [cce_pc_width_p-1:0] next_pc_o
);
    // Increment wraps naturally at the PC width.
    assign next_pc_o = ~yumi_i ? pc_i
                     : branch_v_i ? branch_target_i
                     : pc_i + cce_pc_width_p'(1);
endmodule

// File: rtl/bp_cce_inst_fetch_ctrl.sv
// bp_cce_inst_fetch_ctrl: CCE microcode fetch controller with halted-mode config RAM access
// Ports: clk_i/reset_i (async active-high); mode_i run/halt; start_pc_i first PC;
//        cfg_* config request/response; ram_* single-port sync RAM; inst_v_o/inst_o/pc_o
//        fetched instruction with inst_yumi_i handshake; branch_v_i/branch_target_i redirect.
// Macro BP_CCE_FETCH_BRANCH_BYPASS_EN: branch target read issued in the yumi cycle (no bubble);
// otherwise the target is registered and read from a one-cycle redirect state.
module bp_cce_inst_fetch_ctrl
    import bp_me_pkg::*;
#(
    parameter int cce_pc_width_p   = 8,
    parameter int cce_inst_width_p = 48
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        mode_i,
    input  logic [cce_pc_width_p-1:0]   start_pc_i,
    input  logic                        cfg_v_i,
    input  logic                        cfg_w_i,
    input  logic [cce_pc_width_p-1:0]   cfg_addr_i,
    input  logic [cce_inst_width_p-1:0] cfg_data_i,
    output logic                        cfg_ready_o,
    output logic                        cfg_data_v_o,
    output logic [cce_inst_width_p-1:0] cfg_data_o,
    output logic                        ram_v_o,
    output logic                        ram_w_o,
    output logic [cce_pc_width_p-1:0]   ram_addr_o,
    output logic [cce_inst_width_p-1:0] ram_data_o,
    input  logic [cce_inst_width_p-1:0] ram_data_i,
    output logic                        inst_v_o,
    output logic [cce_inst_width_p-1:0] inst_o,
    output logic [cce_pc_width_p-1:0]   pc_o,
    input  logic                        inst_yumi_i,
    input  logic                        branch_v_i,
    input  logic [cce_pc_width_p-1:0]   branch_target_i
);
    bp_cce_fetch_state_e state_r, state_n;
    logic [cce_pc_width_p-1:0] pc_r, next_pc;
    logic cfg_rd_r, run, halt, cfg_acc;

    assign run  = state_r == e_run;
    assign halt = state_r == e_halt;
    assign cfg_ready_o = halt & ~reset_i;
    assign cfg_acc = cfg_v_i & cfg_ready_o;

    bp_cce_fetch_pc_gen #(.cce_pc_width_p(cce_pc_width_p)) pc_gen (
        .pc_i(pc_r),
        .yumi_i(run & inst_yumi_i),
        .branch_v_i(branch_v_i),
        .branch_target_i(branch_target_i),
        .next_pc_o(next_pc)
    );

    always_comb begin
        state_n = e_run;
        if (!mode_i) state_n = e_halt;
        else if (halt) state_n = e_prime;
`ifndef BP_CCE_FETCH_BRANCH_BYPASS_EN
        else if (run & inst_yumi_i & branch_v_i) state_n = e_redirect;
`endif
    end

    // Running states read every cycle; the RAM re-read on a stall keeps inst_o stable.
    assign ram_v_o    = cfg_acc | ~halt;
    assign ram_w_o    = cfg_acc & cfg_w_i;
    assign ram_addr_o = halt ? cfg_addr_i
                      : state_r == e_prime ? start_pc_i
                      : run ? next_pc
                      : pc_r;
    assign ram_data_o = cfg_acc ? cfg_data_i : '0;

    assign inst_v_o     = run;
    assign inst_o       = run ? ram_data_i : '0;
    assign pc_o         = pc_r;
    assign cfg_data_v_o = cfg_rd_r;
    assign cfg_data_o   = cfg_rd_r ? ram_data_i : '0;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r  <= e_halt;
            pc_r     <= '0;
            cfg_rd_r <= 1'b0;
        end else begin
            state_r  <= state_n;
            cfg_rd_r <= cfg_acc & ~cfg_w_i;
            if (state_r == e_prime) pc_r <= start_pc_i;
            else if (run) pc_r <= next_pc;
        end
    end
endmodule

// File: tb/tb_bp_cce_inst_fetch_ctrl.sv
// tb_bp_cce_inst_fetch_ctrl: table-driven and randomized checks of the CCE fetch controller
module tb_bp_cce_inst_fetch_ctrl;
    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        mode_i = 1'b0;
    logic [7:0]  start_pc_i = '0;
    logic        cfg_v_i = 1'b0, cfg_w_i = 1'b0;
    logic [7:0]  cfg_addr_i = '0;
    logic [47:0] cfg_data_i = '0;
    logic        cfg_ready_o, cfg_data_v_o;
    logic [47:0] cfg_data_o;
    logic        ram_v_o, ram_w_o;
    logic [7:0]  ram_addr_o;
    logic [47:0] ram_data_o, ram_data_i;
    logic        inst_v_o;
    logic [47:0] inst_o;
    logic [7:0]  pc_o;
    logic        inst_yumi_i = 1'b0, branch_v_i = 1'b0;
    logic [7:0]  branch_target_i = '0;

    bp_cce_inst_fetch_ctrl #(.cce_pc_width_p(8), .cce_inst_width_p(48)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .mode_i(mode_i), .start_pc_i(start_pc_i),
        .cfg_v_i(cfg_v_i), .cfg_w_i(cfg_w_i), .cfg_addr_i(cfg_addr_i), .cfg_data_i(cfg_data_i),
        .cfg_ready_o(cfg_ready_o), .cfg_data_v_o(cfg_data_v_o), .cfg_data_o(cfg_data_o),
        .ram_v_o(ram_v_o), .ram_w_o(ram_w_o), .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o),
        .ram_data_i(ram_data_i), .inst_v_o(inst_v_o), .inst_o(inst_o), .pc_o(pc_o),
        .inst_yumi_i(inst_yumi_i), .branch_v_i(branch_v_i), .branch_target_i(branch_target_i)
    );

    always #5 clk_i = ~clk_i;

    logic [47:0] mem [256];
    logic [47:0] rdata = '0;
    assign ram_data_i = rdata;
    always @(posedge clk_i)
        if (ram_v_o) begin
            if (ram_w_o) mem[ram_addr_o] <= ram_data_o;
            else rdata <= mem[ram_addr_o];
        end

    // Reference model: expected memory contents, the PC decode should see next,
    // and how many non-valid cycles precede the next delivered instruction.
    logic [47:0] ref_mem [256];
    logic [7:0]  exp_pc = '0;
    int          wait_cnt = 0;
    int          checks = 0, errors = 0;

    typedef struct {
        logic        w;
        logic [7:0]  addr;
        logic [47:0] data;
    } cfg_vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic cfg_op(input logic w, input logic [7:0] a, input logic [47:0] d);
        @(negedge clk_i);
        chk("cfg_dv_idle", 64'(cfg_data_v_o), 64'd0);
        cfg_v_i = 1'b1; cfg_w_i = w; cfg_addr_i = a; cfg_data_i = d;
        #1;
        chk("cfg_ready", 64'(cfg_ready_o), 64'd1);
        chk("cfg_ram_w", 64'(ram_w_o), 64'(w));
        @(negedge clk_i);
        cfg_v_i = 1'b0;
        chk("cfg_dv", 64'(cfg_data_v_o), 64'(!w));
        if (!w) chk("cfg_rdata", 64'(cfg_data_o), 64'(d));
        else ref_mem[a] = d;
    endtask

    task automatic start_run(input logic [7:0] pc);
        @(negedge clk_i);
        start_pc_i = pc; mode_i = 1'b1;
        exp_pc = pc; wait_cnt = 1;
    endtask

    task automatic cycle(input logic y, input logic b, input logic [7:0] t);
        logic exp_v;
        @(negedge clk_i);
        exp_v = (wait_cnt == 0);
        chk("inst_v", 64'(inst_v_o), 64'(exp_v));
        chk("run_cfg_ready", 64'(cfg_ready_o), 64'd0);
        if (exp_v) begin
            chk("pc", 64'(pc_o), 64'(exp_pc));
            chk("inst", 64'(inst_o), 64'(ref_mem[exp_pc]));
        end
        if (wait_cnt > 0) wait_cnt--;
        inst_yumi_i = y & exp_v;
        branch_v_i = b & y & exp_v;
        branch_target_i = t;
        cfg_v_i = 1'($urandom_range(0, 1)); cfg_w_i = 1'b1;
        cfg_addr_i = 8'($urandom); cfg_data_i = '1;
        #1;
        chk("run_no_cfg_write", 64'(ram_w_o), 64'd0);
        if (inst_yumi_i) begin
            exp_pc = branch_v_i ? t : exp_pc + 8'd1;
`ifndef BP_CCE_FETCH_BRANCH_BYPASS_EN
            if (branch_v_i) wait_cnt = 1;
`endif
        end
    endtask

    task automatic stop_run();
        @(negedge clk_i);
        mode_i = 1'b0; inst_yumi_i = 1'b0; branch_v_i = 1'b0; cfg_v_i = 1'b0;
        @(negedge clk_i);
        chk("halt_inst_v", 64'(inst_v_o), 64'd0);
        chk("halt_cfg_ready", 64'(cfg_ready_o), 64'd1);
    endtask

    initial begin
        cfg_vec_t tbl [8];
        logic [7:0] t;
        tbl[0] = '{1'b1, 8'h03, 48'hA5};
        tbl[1] = '{1'b1, 8'h04, 48'h1234_5678_9ABC};
        tbl[2] = '{1'b1, 8'hFF, 48'hFFFF_0000_FFFF};
        tbl[3] = '{1'b0, 8'h03, 48'hA5};
        tbl[4] = '{1'b0, 8'h04, 48'h1234_5678_9ABC};
        tbl[5] = '{1'b0, 8'hFF, 48'hFFFF_0000_FFFF};
        tbl[6] = '{1'b1, 8'h03, 48'h5A};
        tbl[7] = '{1'b0, 8'h03, 48'h5A};

        cfg_v_i = 1'b1;
        #3;
        chk("rst_ram_v", 64'(ram_v_o), 64'd0);
        chk("rst_cfg_ready", 64'(cfg_ready_o), 64'd0);
        chk("rst_inst_v", 64'(inst_v_o), 64'd0);
        chk("rst_cfg_dv", 64'(cfg_data_v_o), 64'd0);
        chk("rst_inst", 64'(inst_o), 64'd0);
        chk("rst_pc", 64'(pc_o), 64'd0);
        cfg_v_i = 1'b0;
        @(negedge clk_i);
        reset_i = 1'b0;

        for (int i = 0; i < 256; i++) cfg_op(1'b1, 8'(i), {$urandom, 16'($urandom)});
        for (int i = 0; i < 8; i++) cfg_op(tbl[i].w, tbl[i].addr, tbl[i].data);

        start_run(8'h02);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b1, 1'b1, 8'h10);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'h00);
        stop_run();

        start_run(8'hFD);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b1, 1'b1, exp_pc);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'h00);
        stop_run();

        // Config read accepted in the same cycle mode rises still completes.
        @(negedge clk_i);
        mode_i = 1'b1; start_pc_i = 8'h40;
        cfg_v_i = 1'b1; cfg_w_i = 1'b0; cfg_addr_i = 8'h04;
        @(negedge clk_i);
        cfg_v_i = 1'b0;
        chk("mode_rise_cfg_dv", 64'(cfg_data_v_o), 64'd1);
        chk("mode_rise_cfg_data", 64'(cfg_data_o), 64'h1234_5678_9ABC);
        exp_pc = 8'h40; wait_cnt = 0;
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'h00);
        stop_run();

        for (int r = 0; r < 6; r++) begin
            start_run(8'($urandom));
            for (int i = 0; i < 120; i++) begin
                case ($urandom_range(0, 3))
                    0: t = exp_pc;
                    1: t = 8'hFF;
                    default: t = 8'($urandom);
                endcase
                cycle(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 4) == 0), t);
            end
            stop_run();
        end

        // Config read aborted by a reset pulse in its response cycle.
        @(negedge clk_i);
        cfg_v_i = 1'b1; cfg_w_i = 1'b0; cfg_addr_i = 8'h03;
        @(posedge clk_i);
        #1;
        reset_i = 1'b1; cfg_v_i = 1'b0;
        #1;
        chk("abort_cfg_dv", 64'(cfg_data_v_o), 64'd0);
        chk("abort_cfg_data", 64'(cfg_data_o), 64'd0);
        chk("abort_ram_v", 64'(ram_v_o), 64'd0);
        chk("abort_cfg_ready", 64'(cfg_ready_o), 64'd0);
        chk("abort_inst_v", 64'(inst_v_o), 64'd0);
        @(negedge clk_i);
        reset_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("post_rst_cfg_dv", 64'(cfg_data_v_o), 64'd0);
        end

        // Reset during a fetch stream.
        start_run(8'h20);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'h00);
        @(negedge clk_i);
        reset_i = 1'b1; mode_i = 1'b0; inst_yumi_i = 1'b0; cfg_v_i = 1'b0;
        #1;
        chk("run_rst_inst_v", 64'(inst_v_o), 64'd0);
        chk("run_rst_inst", 64'(inst_o), 64'd0);
        chk("run_rst_pc", 64'(pc_o), 64'd0);
        chk("run_rst_ram_v", 64'(ram_v_o), 64'd0);
        @(negedge clk_i);
        reset_i = 1'b0;
        @(negedge clk_i);
        chk("post_rst_inst_v", 64'(inst_v_o), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
